// File: rtl/sdram_ring_sched.sv
// Burst scheduler sharing one SDRAM command port between the pipe-in write path
// and the pipe-out read path, with SDRAM managed as one circular buffer.
module sdram_ring_sched #(
    parameter int ADDR_WIDTH = 24,
    parameter int BURST_LOG2 = 8
) (
    input  logic                  sdram_clk,
    input  logic                  a_rst,
    input  logic                  clr,
    input  logic                  read_enable,
    input  logic                  wr_ready,
    input  logic                  rd_ready,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  done,
    output logic [ADDR_WIDTH:0]   fill,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0]   BURST_F  = (ADDR_WIDTH+1)'(1) << BURST_LOG2;
    localparam logic [ADDR_WIDTH:0]   FILL_MAX = ((ADDR_WIDTH+1)'(1) << ADDR_WIDTH) - BURST_F;
    localparam logic [ADDR_WIDTH-1:0] BURST_A  = ADDR_WIDTH'(1) << BURST_LOG2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  last_wr;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  grant_wr;

    assign wr_elig  = wr_ready && (fill <= FILL_MAX);
    assign rd_elig  = rd_ready && read_enable && (fill >= BURST_F);
    // Contested grants go to read only when the previous grant was a write.
    assign grant_wr = wr_elig && !(rd_elig && last_wr);

    always_ff @(posedge sdram_clk or posedge a_rst) begin
        if (a_rst) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            busy      <= 1'b0;
            last_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        fill   <= '0;
                    end else if (wr_elig || rd_elig) begin
                        cmd_write <= grant_wr;
                        cmd_addr  <= grant_wr ? wr_ptr : rd_ptr;
                        last_wr   <= grant_wr;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Ring bookkeeping commits only once the controller reports completion.
                    if (done) begin
                        if (cmd_write) begin
                            wr_ptr <= wr_ptr + BURST_A;
                            fill   <= fill + BURST_F;
                        end else begin
                            rd_ptr <= rd_ptr + BURST_A;
                            fill   <= fill - BURST_F;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ring_sched.sv
// Directed bench for sdram_ring_sched: a default-size instance for sequencing,
// arbitration, backpressure, clr and reset, plus a 10-bit instance for ring wrap.
module tb_sdram_ring_sched;

    logic sdram_clk = 1'b0;
    logic a_rst, clr, read_enable, wr_ready, rd_ready, cmd_ready, done;

    logic        cv0, cw0, b0;
    logic [23:0] ca0;
    logic [24:0] f0;
    logic        cv1, cw1, b1;
    logic [9:0]  ca1;
    logic [10:0] f1;

    logic        cv, cw, busy_m;
    logic [23:0] ca;
    logic [24:0] fill_m;
    bit          sel;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 sdram_clk = ~sdram_clk;

    sdram_ring_sched dut_big (
        .sdram_clk(sdram_clk), .a_rst(a_rst), .clr(clr), .read_enable(read_enable),
        .wr_ready(wr_ready), .rd_ready(rd_ready), .cmd_valid(cv0), .cmd_ready(cmd_ready),
        .cmd_write(cw0), .cmd_addr(ca0), .done(done), .fill(f0), .busy(b0)
    );

    sdram_ring_sched #(.ADDR_WIDTH(10), .BURST_LOG2(8)) dut_small (
        .sdram_clk(sdram_clk), .a_rst(a_rst), .clr(clr), .read_enable(read_enable),
        .wr_ready(wr_ready), .rd_ready(rd_ready), .cmd_valid(cv1), .cmd_ready(cmd_ready),
        .cmd_write(cw1), .cmd_addr(ca1), .done(done), .fill(f1), .busy(b1)
    );

    always_comb begin
        cv     = sel ? cv1 : cv0;
        cw     = sel ? cw1 : cw0;
        busy_m = sel ? b1 : b0;
        ca     = sel ? {14'd0, ca1} : ca0;
        fill_m = sel ? {14'd0, f1} : f0;
    end

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cv) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("cmd_seen", 32'(ok), 32'd1);
    endtask

    // One full burst: expect a command, optionally hold it off, accept, then complete.
    task automatic do_burst(input logic w, input logic [23:0] a, input logic [24:0] fa,
                            input int hold, input bit clr_wait);
        bit ok;
        logic [25:0] snap;
        wait_cv(ok);
        if (ok) begin
            check("cmd_write", 32'(cw), 32'(w));
            check("cmd_addr", 32'(ca), 32'(a));
            snap = {cv, cw, ca};
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_stable", 32'({cv, cw, ca}), 32'(snap));
            end
            cmd_ready = 1'b1;
            tick();
            check("accepted", 32'(cv), 32'd0);
            check("busy_wait", 32'(busy_m), 32'd1);
            if (clr_wait) clr = 1'b1;
            repeat (3) tick();
            clr  = 1'b0;
            done = 1'b1;
            tick();
            done = 1'b0;
            check("fill", 32'(fill_m), 32'(fa));
            check("busy_idle", 32'(busy_m), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit saw;
        a_rst = 1'b1; clr = 1'b0; read_enable = 1'b0; wr_ready = 1'b0;
        rd_ready = 1'b0; cmd_ready = 1'b0; done = 1'b0; sel = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(cv0), 32'd0);
        check("rst_write", 32'(cw0), 32'd0);
        check("rst_addr", 32'(ca0), 32'd0);
        check("rst_fill", 32'(f0), 32'd0);
        check("rst_busy", 32'(b0), 32'd0);
        a_rst = 1'b0;

        // Basic flow: write, read, write.
        wr_ready = 1'b1; rd_ready = 1'b1; read_enable = 1'b1; cmd_ready = 1'b1;
        do_burst(1'b1, 24'h000000, 25'd256, 0, 1'b0);
        do_burst(1'b0, 24'h000000, 25'd0,   0, 1'b0);
        do_burst(1'b1, 24'h000100, 25'd256, 0, 1'b0);

        // Build fill to 512, then contention alternates R,W,R,W.
        rd_ready = 1'b0;
        do_burst(1'b1, 24'h000200, 25'd512, 0, 1'b0);
        rd_ready = 1'b1;
        do_burst(1'b0, 24'h000100, 25'd256, 0, 1'b0);
        do_burst(1'b1, 24'h000300, 25'd512, 0, 1'b0);
        do_burst(1'b0, 24'h000200, 25'd256, 0, 1'b0);
        do_burst(1'b1, 24'h000400, 25'd512, 0, 1'b0);

        // Backpressure on a read command for 10 cycles.
        cmd_ready = 1'b0;
        do_burst(1'b0, 24'h000300, 25'd256, 10, 1'b0);

        // clr during WAIT is ignored.
        do_burst(1'b1, 24'h000500, 25'd512, 0, 1'b1);

        // clr in IDLE with fill=768 clears the ring and issues nothing.
        rd_ready = 1'b0;
        do_burst(1'b1, 24'h000600, 25'd768, 0, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_no_cmd", 32'(cv), 32'd0);
        check("clr_fill", 32'(fill_m), 32'd0);
        check("clr_busy", 32'(busy_m), 32'd0);
        do_burst(1'b1, 24'h000000, 25'd256, 0, 1'b0);

        // read_enable=0 blocks reads even with data available.
        wr_ready = 1'b0; read_enable = 1'b0; rd_ready = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (cv) saw = 1'b1;
        end
        check("rd_disabled_no_cmd", 32'(saw), 32'd0);
        check("rd_disabled_fill", 32'(fill_m), 32'd256);
        read_enable = 1'b1;
        do_burst(1'b0, 24'h000000, 25'd0, 0, 1'b0);

        // Asynchronous reset in WAIT.
        rd_ready = 1'b0; wr_ready = 1'b1;
        do_burst(1'b1, 24'h000100, 25'd256, 0, 1'b0);
        wait_cv(ok);
        check("rstw_addr", 32'(ca), 32'h200);
        tick();
        check("rstw_busy_pre", 32'(busy_m), 32'd1);
        tick();
        a_rst = 1'b1;
        #1;
        check("rstw_valid", 32'(cv0), 32'd0);
        check("rstw_fill", 32'(f0), 32'd0);
        check("rstw_busy", 32'(b0), 32'd0);
        wr_ready = 1'b0;
        #2;
        a_rst = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("stray_done_fill", 32'(f0), 32'd0);
        check("stray_done_busy", 32'(b0), 32'd0);

        // Ring wrap on the 10-bit instance.
        a_rst = 1'b1;
        sel = 1'b1;
        tick();
        a_rst = 1'b0;
        check("wrap_rst_fill", 32'(fill_m), 32'd0);
        wr_ready = 1'b1; rd_ready = 1'b0; read_enable = 1'b1; cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            do_burst(1'b1, 24'(i * 256), 25'((i + 1) * 256), 0, 1'b0);
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (cv) saw = 1'b1;
        end
        check("full_no_cmd", 32'(saw), 32'd0);
        check("full_fill", 32'(fill_m), 32'd1024);
        rd_ready = 1'b1;
        do_burst(1'b0, 24'h000, 25'd768, 0, 1'b0);
        rd_ready = 1'b0;
        do_burst(1'b1, 24'h000, 25'd1024, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
